// File: rtl/adder_pkg.sv
// Shared types for the adder front end: datapath width, word type and the
// accumulate controller state encoding.
package adder_pkg;

   localparam int ADDER_WIDTH = 16;

   typedef logic [ADDER_WIDTH-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      LOAD   = 2'd2,
      HOLD   = 2'd3
   } acc_state_t;

endpackage

// File: rtl/accumulate_ctrl_sync_edge.sv
// Button synchroniser followed by a rising-edge detector. The previous-value
// register is forced to PREV_INIT until the chain has refilled after reset.
module sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic PREV_INIT = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise
);

   logic [STAGES-1:0] chain;
   logic [STAGES-1:0] fill;
   logic              prev;

   // The chain holds reset zeros, not real samples, until 'fill' is full.
   // Tracking those zeros would fake a release and let a held button fire.
   always_ff @(posedge clk) begin
      if (reset) begin
         chain <= '0;
         fill  <= '0;
         prev  <= PREV_INIT;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         fill  <= {fill[STAGES-2:0], 1'b1};
         prev  <= fill[STAGES-1] ? chain[STAGES-1] : PREV_INIT;
      end
   end

   assign level = chain[STAGES-1];
   assign rise  = level & ~prev;

endmodule

// File: rtl/accumulate_ctrl.sv
// Accumulator front end for an external 16-bit adder: captures SW on a Run press,
// holds the adder operands for SETTLE_CYCLES, then loads S/cout into Acc.
// Optional signed-overflow flag is built only when ACC_OVF_EN is defined.
module accumulate_ctrl
   import adder_pkg::*;
#(
   parameter int WIDTH         = ADDER_WIDTH,
   parameter int SETTLE_CYCLES = 2,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Run,
   input  logic             Clear,
   input  logic [WIDTH-1:0] SW,
   input  logic [WIDTH-1:0] S,
   input  logic             cout,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic             cin_out,
   output logic [WIDTH-1:0] Acc,
   output logic             Cout_flag,
   output logic             Ovf,
   output logic             Busy,
   output logic             Done,
   output logic [1:0]       state_dbg
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   acc_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] acc_q, b_q;
   logic             cflag_q, done_q;
   logic             run_s, run_rise, clr_rise;
   logic             ld_b, ld_acc, clr_acc;

   sync_edge #(.STAGES(SYNC_STAGES), .PREV_INIT(1'b1)) u_run_sync (
      .clk   (Clk),
      .reset (Reset),
      .din   (Run),
      .level (run_s),
      .rise  (run_rise)
   );

   logic clr_s_unused;
   sync_edge #(.STAGES(SYNC_STAGES), .PREV_INIT(1'b1)) u_clr_sync (
      .clk   (Clk),
      .reset (Reset),
      .din   (Clear),
      .level (clr_s_unused),
      .rise  (clr_rise)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ld_b    = 1'b0;
      ld_acc  = 1'b0;
      clr_acc = 1'b0;
      case (state)
         IDLE: begin
            // Clear takes priority; a coincident Run edge is dropped, not deferred.
            if (clr_rise) begin
               clr_acc = 1'b1;
            end else if (run_rise) begin
               ld_b    = 1'b1;
               cnt_n   = '0;
               state_n = SETTLE;
            end
         end
         SETTLE: begin
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_LAST) state_n = LOAD;
         end
         LOAD: begin
            ld_acc  = 1'b1;
            state_n = HOLD;
         end
         HOLD: begin
            if (!run_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         cflag_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         done_q <= ld_acc;
         if (ld_b) b_q <= SW;
         if (clr_acc) begin
            acc_q   <= '0;
            cflag_q <= 1'b0;
         end else if (ld_acc) begin
            acc_q   <= S;
            cflag_q <= cout;
         end
      end
   end

`ifdef ACC_OVF_EN
   logic ovf_q;
   logic ovf_calc;

   // Operands share a sign but the sum does not: two's-complement overflow.
   assign ovf_calc = (acc_q[WIDTH-1] == b_q[WIDTH-1]) & (S[WIDTH-1] != acc_q[WIDTH-1]);

   always_ff @(posedge Clk) begin
      if (Reset || clr_acc) ovf_q <= 1'b0;
      else if (ld_acc)      ovf_q <= ovf_calc;
   end

   assign Ovf = ovf_q;
`else
   assign Ovf = 1'b0;
`endif

   assign x_out     = acc_q;
   assign y_out     = b_q;
   assign cin_out   = 1'b0;
   assign Acc       = acc_q;
   assign Cout_flag = cflag_q;
   assign Done      = done_q;
   assign Busy      = (state == SETTLE) || (state == LOAD);
   assign state_dbg = state;

endmodule
